// File: rtl/rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv32i_instr_encoder
// Encodes abstract ALU operation requests into RV32I R-type / I-type words
// and streams them sequentially into instruction memory.
//
// Optional feature macro: ENC_NOP_PAD_EN
//   When defined, a flush pulse in IDLE pads every remaining address with
//   0x00000013 (addi x0,x0,0) and then ends in FULL. When undefined, flush
//   is ignored and the PAD state does not exist.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   prog_start        synchronous restart (clears pointer, count, full)
//   req_valid/ready   request handshake; req_op/is_imm/rd/rs1/rs2/imm payload
//   flush             pad request (optional feature only)
//   mem_we/addr/wdata instruction memory write port, held until mem_ready
//   mem_ready         memory accepts the write
//   err               one-cycle pulse after an illegal request is accepted
//   full              DEPTH words written
//   count             number of words written
// ---------------------------------------------------------------------------
module rv32i_instr_encoder #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned BASE_WORD = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prog_start,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic              req_is_imm,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [4:0]        req_rs2,
   input  logic [11:0]       req_imm,
   input  logic              flush,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              err,
   output logic              full,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned       CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_WORD);
   localparam logic [31:0]       NOP_WORD = 32'h0000_0013;
   localparam logic [6:0]        OPC_R    = 7'b0110011;
   localparam logic [6:0]        OPC_I    = 7'b0010011;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
`ifdef ENC_NOP_PAD_EN
      S_PAD   = 2'd3,
`endif
      S_FULL  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    count_nxt;
   logic                full_nxt, err_nxt, mem_we_nxt;
   logic [ADDR_W-1:0]   mem_addr_nxt;
   logic [31:0]         mem_wdata_nxt;

   logic [2:0]          funct3;
   logic [6:0]          funct7;
   logic                op_known, imm_ok, legal;
   logic [31:0]         enc_word;

   // Write pointer always equals the number of words written (mod 2^ADDR_W).
   logic [ADDR_W-1:0]   wptr;
   logic [CNT_W-1:0]    count_inc;
   logic                last_word;

   assign wptr      = count[ADDR_W-1:0];
   assign count_inc = count + CNT_W'(1);
   assign last_word = (count_inc == DEPTH_C);

`ifndef ENC_NOP_PAD_EN
   logic unused_flush;
   assign unused_flush = flush;
`endif

   assign req_ready = (state == S_IDLE) & ~prog_start;

   // Request encoder and legality check.
   always_comb begin
      funct3   = 3'b000;
      op_known = 1'b1;
      case (req_op)
         4'd0, 4'd1: funct3 = 3'b000;
         4'd2:       funct3 = 3'b001;
         4'd3:       funct3 = 3'b010;
         4'd4:       funct3 = 3'b011;
         4'd5:       funct3 = 3'b100;
         4'd6, 4'd7: funct3 = 3'b101;
         4'd8:       funct3 = 3'b110;
         4'd9:       funct3 = 3'b111;
         default:    op_known = 1'b0;
      endcase
      imm_ok   = (req_op == 4'd0) | (req_op == 4'd3) | (req_op == 4'd8) | (req_op == 4'd9);
      legal    = op_known & (~req_is_imm | imm_ok);
      funct7   = ((req_op == 4'd1) | (req_op == 4'd7)) ? 7'b0100000 : 7'b0000000;
      enc_word = req_is_imm ? {req_imm, req_rs1, funct3, req_rd, OPC_I}
                            : {funct7, req_rs2, req_rs1, funct3, req_rd, OPC_R};
   end

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         count     <= '0;
         full      <= 1'b0;
         err       <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_C;
         mem_wdata <= '0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         full      <= full_nxt;
         err       <= err_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
      end
   end

   // Next-state logic. A request wins over a simultaneous flush.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (prog_start) begin
               state_nxt = S_IDLE;
            end else if (req_valid) begin
               if (legal) state_nxt = S_WRITE;
`ifdef ENC_NOP_PAD_EN
            end else if (flush) begin
               state_nxt = S_PAD;
`endif
            end
         end
         S_WRITE: begin
            if (mem_ready) state_nxt = last_word ? S_FULL : S_IDLE;
         end
         S_FULL: begin
            if (prog_start) state_nxt = S_IDLE;
         end
`ifdef ENC_NOP_PAD_EN
         S_PAD: begin
            if (mem_ready && last_word) state_nxt = S_FULL;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      count_nxt     = count;
      full_nxt      = full;
      err_nxt       = 1'b0;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      case (state)
         S_IDLE: begin
            if (prog_start) begin
               count_nxt    = '0;
               full_nxt     = 1'b0;
               mem_we_nxt   = 1'b0;
               mem_addr_nxt = BASE_C;
            end else if (req_valid) begin
               if (legal) begin
                  mem_we_nxt    = 1'b1;
                  mem_addr_nxt  = BASE_C + wptr;
                  mem_wdata_nxt = enc_word;
               end else begin
                  err_nxt = 1'b1;
               end
`ifdef ENC_NOP_PAD_EN
            end else if (flush) begin
               mem_we_nxt    = 1'b1;
               mem_addr_nxt  = BASE_C + wptr;
               mem_wdata_nxt = NOP_WORD;
`endif
            end
         end
         S_WRITE: begin
            if (mem_ready) begin
               mem_we_nxt = 1'b0;
               count_nxt  = count_inc;
               full_nxt   = last_word;
            end
         end
         S_FULL: begin
            if (prog_start) begin
               count_nxt    = '0;
               full_nxt     = 1'b0;
               mem_addr_nxt = BASE_C;
            end
         end
`ifdef ENC_NOP_PAD_EN
         // Keep streaming NOPs to consecutive addresses until the last one.
         S_PAD: begin
            if (mem_ready) begin
               count_nxt = count_inc;
               if (last_word) begin
                  mem_we_nxt = 1'b0;
                  full_nxt   = 1'b1;
               end else begin
                  mem_addr_nxt = BASE_C + count_inc[ADDR_W-1:0];
               end
            end
         end
`endif
         default: begin
            mem_we_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_rv32i_instr_encoder
// Table-driven directed vectors, hand sequences for full/restart/reset/pad,
// and randomized traffic checked against a transaction-level model
// (occupancy, word count, pending word) kept in the bench.
// ---------------------------------------------------------------------------
module tb_rv32i_instr_encoder;

   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned BASE_WORD = 0;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              prog_start, req_valid, req_ready, req_is_imm, flush;
   logic [3:0]        req_op;
   logic [4:0]        req_rd, req_rs1, req_rs2;
   logic [11:0]       req_imm;
   logic              mem_we, mem_ready, err, full;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;

   rv32i_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_WORD(BASE_WORD)) dut (
      .clk(clk), .rst_n(rst_n), .prog_start(prog_start),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_is_imm(req_is_imm), .req_rd(req_rd), .req_rs1(req_rs1),
      .req_rs2(req_rs2), .req_imm(req_imm), .flush(flush),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .err(err), .full(full), .count(count)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          n_writes = 0;
   logic [31:0] last_wr = '0;

   // Reference model state.
   int          m_count = 0;
   bit          m_busy  = 1'b0;
   bit          m_pad   = 1'b0;
   bit          m_err   = 1'b0;
   logic [31:0] m_word  = '0;
   int          m_addr  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_ref(int op, bit imm, int rd, int rs1, int rs2, int iv);
      int f3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
      logic [31:0] w;
      w = 32'(f3[op]) * 32'h1000 + 32'(rd) * 32'h80 + 32'(rs1) * 32'h8000;
      if (imm) begin
         w = w + 32'(iv) * 32'h10_0000 + 32'h13;
      end else begin
         w = w + 32'(rs2) * 32'h10_0000 + 32'h33;
         if (op == 1 || op == 7) w = w + 32'h4000_0000;
      end
      return w;
   endfunction

   function automatic bit legal_ref(int op, bit imm);
      if (op > 9) return 1'b0;
      if (imm && !(op == 0 || op == 3 || op == 8 || op == 9)) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: check handshake-visible values before the edge, advance the
   // model by what the edge should do, then check the registered outputs.
   task automatic cycle();
      bit exp_ready;
      #1;
      exp_ready = !m_busy && (m_count != DEPTH) && !prog_start;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (mem_we && mem_ready) begin
         n_writes++;
         last_wr = mem_wdata;
      end
      @(posedge clk);
      m_err = 1'b0;
      if (m_busy) begin
         if (mem_ready) begin
            m_count++;
            if (m_pad && m_count < DEPTH) begin
               m_addr = (BASE_WORD + m_count) % (1 << ADDR_W);
            end else begin
               m_busy = 1'b0;
               m_pad  = 1'b0;
            end
         end
      end else if (prog_start) begin
         m_count = 0;
      end else if (m_count == DEPTH) begin
         m_count = m_count;
      end else if (req_valid) begin
         if (legal_ref(int'(req_op), req_is_imm)) begin
            m_busy = 1'b1;
            m_word = enc_ref(int'(req_op), req_is_imm, int'(req_rd), int'(req_rs1),
                             int'(req_rs2), int'(req_imm));
            m_addr = (BASE_WORD + m_count) % (1 << ADDR_W);
         end else begin
            m_err = 1'b1;
         end
`ifdef ENC_NOP_PAD_EN
      end else if (flush) begin
         m_busy = 1'b1;
         m_pad  = 1'b1;
         m_word = 32'h13;
         m_addr = (BASE_WORD + m_count) % (1 << ADDR_W);
`endif
      end
      @(negedge clk);
      chk("mem_we", 32'(mem_we), 32'(m_busy));
      if (m_busy) begin
         chk("mem_addr", 32'(mem_addr), 32'(m_addr));
         chk("mem_wdata", mem_wdata, m_word);
      end
      chk("err", 32'(err), 32'(m_err));
      chk("count", 32'(count), 32'(m_count));
      chk("full", 32'(full), 32'(m_count == DEPTH));
   endtask

   typedef struct {
      logic [3:0]  op;
      logic        imm;
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] iv;
      logic [31:0] word;
      bit          ill;
      int          hold;
   } vec_t;

   vec_t tbl [9];

   task automatic apply_vec(input vec_t v);
      int w0;
      if (m_count == DEPTH) begin
         prog_start = 1'b1;
         cycle();
         prog_start = 1'b0;
      end
      req_op = v.op; req_is_imm = v.imm; req_rd = v.rd; req_rs1 = v.rs1;
      req_rs2 = v.rs2; req_imm = v.iv;
      req_valid = 1'b1;
      mem_ready = (v.hold == 0);
      w0 = n_writes;
      cycle();
      req_valid = 1'b0;
      for (int h = 0; h < v.hold; h++) cycle();
      mem_ready = 1'b1;
      cycle();
      cycle();
      chk("writes_per_req", 32'(n_writes - w0), v.ill ? 32'd0 : 32'd1);
      if (!v.ill) chk("table_word", last_wr, v.word);
   endtask

   initial begin
      int w0;
      rst_n = 1'b0; prog_start = 1'b0; req_valid = 1'b0; req_is_imm = 1'b0;
      req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
      flush = 1'b0; mem_ready = 1'b1;

      //            op     imm   rd     rs1    rs2    imm      word          ill hold
      tbl[0] = '{4'd0,  1'b0, 5'd3,  5'd1,  5'd2,  12'h000, 32'h002081B3, 0, 0};
      tbl[1] = '{4'd1,  1'b0, 5'd5,  5'd6,  5'd7,  12'h000, 32'h407302B3, 0, 5};
      tbl[2] = '{4'd9,  1'b1, 5'd4,  5'd4,  5'd0,  12'hFFF, 32'hFFF27213, 0, 0};
      tbl[3] = '{4'd2,  1'b1, 5'd1,  5'd1,  5'd0,  12'h001, 32'h0,        1, 0};
      tbl[4] = '{4'd12, 1'b0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h0,        1, 0};
      tbl[5] = '{4'd7,  1'b0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h403150B3, 0, 0};
      tbl[6] = '{4'd3,  1'b1, 5'd10, 5'd11, 5'd0,  12'h800, 32'h8005A513, 0, 0};
      tbl[7] = '{4'd8,  1'b0, 5'd31, 5'd31, 5'd31, 12'h000, 32'h01FFEFB3, 0, 0};
      tbl[8] = '{4'd10, 1'b0, 5'd1,  5'd1,  5'd1,  12'h000, 32'h0,        1, 0};

      #12;
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'(BASE_WORD));
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) apply_vec(tbl[i]);

      // Fill to full, then a held request must be ignored.
      for (int k = 0; k < 20 && m_count < DEPTH; k++) begin
         req_op = 4'd0; req_is_imm = 1'b0; req_valid = 1'b1;
         cycle();
      end
      chk("reached_full", 32'(full), 32'd1);
      w0 = n_writes;
      for (int k = 0; k < 3; k++) cycle();
      req_valid = 1'b0;
      chk("full_ignores_req", 32'(n_writes - w0), 32'd0);

      // Restart with a simultaneous request: prog_start wins.
      prog_start = 1'b1; req_valid = 1'b1;
      cycle();
      prog_start = 1'b0; req_valid = 1'b0;
      chk("restart_no_write", 32'(mem_we), 32'd0);
      req_valid = 1'b1; req_op = 4'd5;
      cycle();
      req_valid = 1'b0;
      chk("restart_addr0", 32'(mem_addr), 32'(BASE_WORD));
      cycle();

      // Asynchronous reset in the middle of a held write.
      mem_ready = 1'b0; req_valid = 1'b1; req_op = 4'd4;
      cycle();
      req_valid = 1'b0;
      cycle();
      rst_n = 1'b0;
      #1;
      chk("async_rst_we", 32'(mem_we), 32'd0);
      chk("async_rst_count", 32'(count), 32'd0);
      m_busy = 1'b0; m_pad = 1'b0; m_count = 0; m_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b1;
      cycle();

`ifdef ENC_NOP_PAD_EN
      req_valid = 1'b1; req_op = 4'd0; req_is_imm = 1'b0;
      cycle();
      req_valid = 1'b0;
      cycle();
      w0 = n_writes;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      for (int k = 0; k < 20 && !(m_count == DEPTH && !m_busy); k++) cycle();
      cycle();
      chk("pad_writes", 32'(n_writes - w0), 32'(DEPTH - 1));
      chk("pad_word", last_wr, 32'h13);
      chk("pad_count", 32'(count), 32'(DEPTH));
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("pad_flush_in_full", 32'(mem_we), 32'd0);
      prog_start = 1'b1;
      cycle();
      prog_start = 1'b0;
`endif

      // Randomized traffic.
      for (int i = 0; i < 2500; i++) begin
         req_valid  = 1'($urandom_range(0, 1));
         req_op     = 4'($urandom_range(0, 11));
         req_is_imm = 1'($urandom_range(0, 1));
         req_rd     = 5'($urandom);
         req_rs1    = 5'($urandom);
         req_rs2    = 5'($urandom);
         req_imm    = 12'($urandom);
         mem_ready  = ($urandom_range(0, 3) != 0);
         prog_start = ($urandom_range(0, 15) == 0);
         flush      = ($urandom_range(0, 31) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Inverse of the core's instruction decoder: takes an abstract ALU operation request (4-bit ALU op code, register indices, optional 12-bit immediate) and encodes it as an RV32I R-type or I-type word.
- Streams encoded words sequentially into instruction memory through a write port with a ready handshake.
- Used as the program loader and test-program generator ahead of the single-cycle core's instruction fetch.

Parameters:
- ADDR_W, 8: width of the word address and write pointer.
- DEPTH, 256: number of words that may be written (1..2^ADDR_W).
- BASE_WORD, 0: word address of the first write.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- prog_start  in  1  synchronous restart: clears the pointer, full and count.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  4  ALU op: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and.
- req_is_imm  in  1  1 = I-type (opcode 0010011), 0 = R-type (opcode 0110011).
- req_rd, req_rs1, req_rs2  in  5 each  register indices; rs2 is ignored for I-type.
- req_imm  in  12  I-type immediate, placed verbatim in bits [31:20].
- flush  in  1  pad request (used only with the optional feature).
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  memory accepts the write when mem_we & mem_ready.
- err  out  1  one-cycle pulse on an illegal request.
- full  out  1  DEPTH words have been written.
- count  out  ADDR_W+1  number of words written.

Behaviour:
- Reset values: state IDLE, wptr=0, count=0, full=0, err=0, mem_we=0, mem_wdata=0, mem_addr=BASE_WORD. req_ready is 1 after reset.
- req_ready = (state==IDLE) & ~prog_start.
- Encoding, R-type:
  - Bits [31:25] = 0100000 for sub/sra, else 0000000.
  - rs2 at [24:20], rs1 at [19:15], funct3 at [14:12], rd at [11:7], opcode 0110011.
- Encoding, I-type: imm at [31:20], rs1, funct3, rd, opcode 0010011.
- funct3 map: add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111.
- Legal I-type ops: add, slt, or, and only.
- Illegal requests: op ≥ 1010, or I-type with any other op.
  - The request is accepted, err pulses on the next cycle, and nothing is written.
  - State stays IDLE; wptr and count are unchanged.
- State machine:
  - IDLE, accept legal request: register the word into mem_wdata, mem_addr = BASE_WORD + wptr, mem_we=1, go to WRITE. Latency is 1 cycle from accept to mem_we.
  - WRITE: hold mem_we, mem_addr and mem_wdata stable until mem_ready. On mem_ready, in the same cycle:
    - mem_we drops next cycle.
    - wptr and count increment.
    - If count+1 == DEPTH, set full and go to FULL; otherwise go to IDLE.
  - FULL: req_ready=0 and requests are ignored. Only prog_start or reset leaves this state.
- prog_start:
  - Honoured in IDLE and FULL: wptr=0, count=0, full=0, go to IDLE.
  - Ignored in WRITE and PAD; the in-flight write is never aborted.
  - If prog_start and req_valid occur together in IDLE, prog_start wins and the request is not accepted.
- Reset mid-WRITE: mem_we drops immediately (asynchronous) and all state returns to reset values.
- Back-to-back: maximum throughput is one word per 2 cycles (IDLE→WRITE→IDLE).

Optional Feature:
- Macro: ENC_NOP_PAD_EN.
- Defined: a flush pulse in IDLE (state not FULL) enters state PAD.
  - PAD writes 0x00000013 (addi x0,x0,0) to every remaining address with the same mem_ready handshake, then sets full and goes to FULL.
  - req_ready=0 throughout PAD.
  - flush in FULL is a no-op.
  - flush together with prog_start in IDLE: prog_start wins.
- Not defined: flush is ignored and the PAD state does not exist.

Test Plan:
- Reset, then request add rd=3 rs1=1 rs2=2, mem_ready=1 -> mem_we at addr 0 with wdata 0x002081B3; count=1, req_ready returns high 2 cycles after accept.
- Request sub rd=5 rs1=6 rs2=7, then andi rd=4 rs1=4 imm=0xFFF -> writes 0x407302B3 at addr 0 and 0xFFF27213 at addr 1.
- Hold mem_ready=0 for 5 cycles during a write -> mem_we, mem_addr and mem_wdata held stable; single write on release; count increments once.
- Requests op=0010 with is_imm=1, and op=1100 -> err pulses once per request; no mem_we; count unchanged.
- DEPTH=4, write 4 legal words -> full=1, req_ready=0, the 5th req_valid is ignored; prog_start -> count=0, next write lands at addr 0.
- (ENC_NOP_PAD_EN, DEPTH=4) one write, then flush -> 0x00000013 written at addrs 1, 2, 3; full=1; count=4.
